am_query_loader: RTL and testbench

- Upstream feeder for the associative memory (AM) stage.
- Accepts each query hypervector as a stream of fixed-width words from the encoder/host, together with its ground-truth label.
- Assembles the words into one of two ping-pong banks, then presents a stable full-width query_hv and correct_class to the AM and pulses start_querying.
- Counts completed queries against a programmed dataset size and raises testing_dataset_finished.

---
 rtl/am_query_loader_if.sv | 12 +
 rtl/am_query_loader.sv | 169 ++++++++++++++++
 tb/tb_am_query_loader.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/am_query_loader_if.sv
// Word-stream interface carrying query words and labels from the encoder/host into the loader.
interface am_query_loader_if #(
  parameter int unsigned LOAD_W = 500
);
  logic              in_valid;
  logic              in_ready;
  logic [LOAD_W-1:0] in_data;
  logic [4:0]        in_label;

  modport master (output in_valid, output in_data, output in_label, input in_ready);
  modport slave  (input in_valid, input in_data, input in_label, output in_ready);
endinterface

// File: rtl/am_query_loader.sv
// Query loader for the associative memory: assembles streamed words into ping-pong banks,
// issues each full query to the AM and counts completed queries against the dataset size.
module am_query_loader #(
  parameter int unsigned HV_DIM = 5000,
  parameter int unsigned LOAD_W = 500,
  parameter int unsigned CNT_W  = 11
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic                clear,
  input  logic [CNT_W-1:0]    num_queries,
  am_query_loader_if.slave    ld,
  input  logic                am_done,
  output logic                start_querying,
  output logic [HV_DIM-1:0]   query_hv,
  output logic [4:0]          correct_class,
  output logic                testing_dataset_finished,
  output logic [CNT_W-1:0]    queries_done
);

  localparam int unsigned WORDS = HV_DIM / LOAD_W;
  localparam int unsigned CTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  if ((HV_DIM % LOAD_W) != 0) begin : g_bad_load_w
    $error("HV_DIM must be an integer multiple of LOAD_W");
  end

  typedef enum logic [1:0] {B_EMPTY, B_FULL, B_ACTIVE} bank_st_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_FINISHED} state_e;

  state_e            state_q, state_d;
  bank_st_e          bank_st_q [2];
  bank_st_e          bank_st_d [2];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [CTR_W-1:0]  word_ctr_q, word_ctr_d;
  logic [CNT_W-1:0]  loaded_q, loaded_d;
  logic [CNT_W-1:0]  done_q, done_d;
  logic [CNT_W-1:0]  nq_q, nq_d;
  logic [HV_DIM-1:0] qhv_q, qhv_d;
  logic [4:0]        cls_q, cls_d;
  logic [HV_DIM-1:0] bank_hv_q [2];
  logic [4:0]        bank_lbl_q [2];

  logic [CNT_W-1:0]  nq_eff;
  logic              in_ready_c;
  logic              accept;
  logic              last_word;

  // Dataset size follows the input while idle and is frozen while a query is in flight.
  assign nq_eff     = (state_q == S_IDLE) ? num_queries : nq_q;
  assign in_ready_c = nrst && en && !clear && (bank_st_q[wr_bank_q] == B_EMPTY) &&
                      (loaded_q < nq_eff) && (state_q != S_FINISHED);
  assign accept     = ld.in_valid && in_ready_c;
  assign last_word  = accept && (word_ctr_q == CTR_W'(WORDS - 1));

  assign ld.in_ready               = in_ready_c;
  assign start_querying            = (state_q == S_ISSUE);
  assign testing_dataset_finished  = (state_q == S_FINISHED);
  assign queries_done              = done_q;
  assign query_hv                  = qhv_q;
  assign correct_class             = cls_q;

  // Next-state logic: word fill, bank ownership, issue FSM and counters; clear wins over all.
  always_comb begin
    state_d    = state_q;
    bank_st_d  = bank_st_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    word_ctr_d = word_ctr_q;
    loaded_d   = loaded_q;
    done_d     = done_q;
    nq_d       = nq_eff;
    qhv_d      = qhv_q;
    cls_d      = cls_q;

    if (accept) begin
      if (last_word) begin
        bank_st_d[wr_bank_q] = B_FULL;
        wr_bank_d            = ~wr_bank_q;
        word_ctr_d           = '0;
        loaded_d             = loaded_q + CNT_W'(1);
      end else begin
        word_ctr_d = word_ctr_q + CTR_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (en && (bank_st_q[rd_bank_q] == B_FULL)) begin
          state_d              = S_ISSUE;
          bank_st_d[rd_bank_q] = B_ACTIVE;
          qhv_d                = bank_hv_q[rd_bank_q];
          cls_d                = bank_lbl_q[rd_bank_q];
        end else if (en && (num_queries == '0)) begin
          state_d = S_FINISHED;
        end
      end
      S_ISSUE: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (am_done) begin
          bank_st_d[rd_bank_q] = B_EMPTY;
          rd_bank_d            = ~rd_bank_q;
          if (done_q < nq_q) begin
            done_d = done_q + CNT_W'(1);
          end
          state_d = (done_d == nq_q) ? S_FINISHED : S_IDLE;
        end
      end
      S_FINISHED: state_d = S_FINISHED;
      default:    state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d    = S_IDLE;
      bank_st_d  = '{B_EMPTY, B_EMPTY};
      wr_bank_d  = 1'b0;
      rd_bank_d  = 1'b0;
      word_ctr_d = '0;
      loaded_d   = '0;
      done_d     = '0;
      qhv_d      = '0;
      cls_d      = '0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      bank_st_q  <= '{B_EMPTY, B_EMPTY};
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      word_ctr_q <= '0;
      loaded_q   <= '0;
      done_q     <= '0;
      nq_q       <= '0;
      qhv_q      <= '0;
      cls_q      <= '0;
    end else begin
      state_q    <= state_d;
      bank_st_q  <= bank_st_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      word_ctr_q <= word_ctr_d;
      loaded_q   <= loaded_d;
      done_q     <= done_d;
      nq_q       <= nq_d;
      qhv_q      <= qhv_d;
      cls_q      <= cls_d;
    end
  end

  // Bank storage has no reset; a bank is only read after all of its words were written.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned k = 0; k < WORDS; k++) begin
        if (word_ctr_q == CTR_W'(k)) begin
          bank_hv_q[wr_bank_q][k*LOAD_W +: LOAD_W] <= ld.in_data;
        end
      end
      if (last_word) begin
        bank_lbl_q[wr_bank_q] <= ld.in_label;
      end
    end
  end

endmodule

// File: tb/tb_am_query_loader.sv
// Directed bench for am_query_loader: single query, ping-pong, throttling, simultaneous
// events, dataset limits, reset and clear.
module tb_am_query_loader;

  localparam int unsigned HV_DIM = 5000;
  localparam int unsigned LOAD_W = 500;
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned WORDS  = HV_DIM / LOAD_W;

  logic              clk = 1'b0;
  logic              nrst;
  logic              en;
  logic              clear;
  logic [CNT_W-1:0]  num_queries;
  logic              am_done;
  logic              start_querying;
  logic [HV_DIM-1:0] query_hv;
  logic [4:0]        correct_class;
  logic              testing_dataset_finished;
  logic [CNT_W-1:0]  queries_done;

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int st_cnt = 0;
  logic [4:0] lbl_log [$];

  am_query_loader_if #(.LOAD_W(LOAD_W)) lif ();

  am_query_loader #(.HV_DIM(HV_DIM), .LOAD_W(LOAD_W), .CNT_W(CNT_W)) dut (
    .clk                      (clk),
    .nrst                     (nrst),
    .en                       (en),
    .clear                    (clear),
    .num_queries              (num_queries),
    .ld                       (lif),
    .am_done                  (am_done),
    .start_querying           (start_querying),
    .query_hv                 (query_hv),
    .correct_class            (correct_class),
    .testing_dataset_finished (testing_dataset_finished),
    .queries_done             (queries_done)
  );

  always #5 clk = ~clk;

  // Count accepted words and issue pulses; log the label presented with each pulse.
  always @(posedge clk) begin
    if (lif.in_valid === 1'b1 && lif.in_ready === 1'b1) acc_cnt <= acc_cnt + 1;
    if (start_querying === 1'b1) begin
      st_cnt <= st_cnt + 1;
      lbl_log.push_back(correct_class);
    end
  end

  function automatic logic [LOAD_W-1:0] word_of(input int base, input int i);
    logic [9:0] v;
    v = 10'(base + i);
    return {50{v}};
  endfunction

  function automatic logic [HV_DIM-1:0] exp_hv(input int base);
    logic [HV_DIM-1:0] r;
    for (int i = 0; i < int'(WORDS); i++) r[i*LOAD_W +: LOAD_W] = word_of(base, i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hv(input string tag, input logic [HV_DIM-1:0] obs, input logic [HV_DIM-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      for (int k = 0; k < int'(WORDS); k++) begin
        if (obs[k*LOAD_W +: LOAD_W] !== exp[k*LOAD_W +: LOAD_W]) begin
          $error("FAIL %s: word %0d observed %0h expected %0h", tag, k,
                 obs[k*LOAD_W +: LOAD_W], exp[k*LOAD_W +: LOAD_W]);
          break;
        end
      end
    end
  endtask

  // Offer words [from..to] of a query, waiting (bounded) for in_ready before each accept.
  task automatic send_words(input string tag, input int base, input logic [4:0] label,
                            input int from, input int to);
    int n;
    for (int i = from; i <= to; i++) begin
      lif.in_valid = 1'b1;
      lif.in_data  = word_of(base, i);
      lif.in_label = (i == int'(WORDS) - 1) ? label : 5'd30;
      #0;
      n = 0;
      while (lif.in_ready !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      chk(tag, 32'(lif.in_ready), 32'd1);
      tick();
    end
    lif.in_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (start_querying !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(start_querying), 32'd1);
  endtask

  task automatic pulse_done();
    am_done = 1'b1;
    tick();
    am_done = 1'b0;
  endtask

  task automatic do_clear(input logic [CNT_W-1:0] nq);
    num_queries = nq;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start"}, 32'(start_querying), 32'd0);
    chk({tag, "_fin"}, 32'(testing_dataset_finished), 32'd0);
    chk({tag, "_done"}, 32'(queries_done), 32'd0);
    chk({tag, "_cls"}, 32'(correct_class), 32'd0);
    chk_hv({tag, "_hv"}, query_hv, '0);
  endtask

  int a0, s0, l0;

  initial begin
    nrst = 1'b0; en = 1'b1; clear = 1'b0; num_queries = 11'd1; am_done = 1'b0;
    lif.in_valid = 1'b0; lif.in_data = '0; lif.in_label = '0;

    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(lif.in_ready), 32'd0);
    chk_reset_vals("rst");
    nrst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(lif.in_ready), 32'd1);

    // Single query
    a0 = acc_cnt;
    send_words("t1_rdy", 0, 5'd7, 0, 9);
    chk("t1_start_t1", 32'(start_querying), 32'd0);
    chk("t1_ready_after", 32'(lif.in_ready), 32'd0);
    tick();
    chk("t1_start_t2", 32'(start_querying), 32'd1);
    chk_hv("t1_hv", query_hv, exp_hv(0));
    chk("t1_hv_w0", 32'(query_hv[31:0]), 32'h0000_0000);
    chk("t1_cls", 32'(correct_class), 32'd7);
    chk("t1_acc", 32'(acc_cnt - a0), 32'd10);
    tick();
    chk("t1_start_once", 32'(start_querying), 32'd0);
    chk("t1_fin_pre", 32'(testing_dataset_finished), 32'd0);
    pulse_done();
    chk("t1_done", 32'(queries_done), 32'd1);
    chk("t1_fin", 32'(testing_dataset_finished), 32'd1);

    // Ping-pong with three queries
    do_clear(11'd3);
    chk_reset_vals("clr");
    a0 = acc_cnt; s0 = st_cnt; l0 = lbl_log.size();
    send_words("t2_q1", 100, 5'd3, 0, 9);
    send_words("t2_q2", 200, 5'd12, 0, 9);
    lif.in_valid = 1'b1; lif.in_data = word_of(300, 0); lif.in_label = 5'd30;
    #0;
    chk("t2_stall0", 32'(lif.in_ready), 32'd0);
    tick(); tick(); tick();
    chk("t2_stall3", 32'(lif.in_ready), 32'd0);
    chk("t2_acc20", 32'(acc_cnt - a0), 32'd20);
    am_done = 1'b1;
    #0;
    chk("t2_stall_done", 32'(lif.in_ready), 32'd0);
    tick();
    am_done = 1'b0;
    #0;
    chk("t2_ready_u1", 32'(lif.in_ready), 32'd1);
    chk("t2_start_u1", 32'(start_querying), 32'd0);
    chk("t2_acc_u1", 32'(acc_cnt - a0), 32'd20);
    tick();
    chk("t2_start_u2", 32'(start_querying), 32'd1);
    chk("t2_cls_q2", 32'(correct_class), 32'd12);
    chk_hv("t2_hv_q2", query_hv, exp_hv(200));
    send_words("t2_q3", 300, 5'd25, 1, 9);
    pulse_done();
    wait_start("t2_wait_q3");
    chk("t2_cls_q3", 32'(correct_class), 32'd25);
    chk_hv("t2_hv_q3", query_hv, exp_hv(300));
    tick();
    pulse_done();
    chk("t2_done", 32'(queries_done), 32'd3);
    chk("t2_fin", 32'(testing_dataset_finished), 32'd1);
    chk("t2_starts", 32'(st_cnt - s0), 32'd3);
    chk("t2_acc", 32'(acc_cnt - a0), 32'd30);
    chk("t2_lbl0", 32'(lbl_log[l0]), 32'd3);
    chk("t2_lbl1", 32'(lbl_log[l0 + 1]), 32'd12);
    chk("t2_lbl2", 32'(lbl_log[l0 + 2]), 32'd25);

    // Throttled input, junk data while invalid
    do_clear(11'd1);
    a0 = acc_cnt;
    for (int i = 0; i < int'(WORDS); i++) begin
      lif.in_valid = 1'b1; lif.in_data = word_of(0, i);
      lif.in_label = (i == int'(WORDS) - 1) ? 5'd7 : 5'd30;
      tick();
      lif.in_valid = 1'b0; lif.in_data = {16{32'($urandom)}}; lif.in_label = 5'd31;
      tick();
    end
    chk("t3_acc", 32'(acc_cnt - a0), 32'd10);
    wait_start("t3_wait");
    chk_hv("t3_hv", query_hv, exp_hv(0));
    chk("t3_cls", 32'(correct_class), 32'd7);
    tick();
    pulse_done();
    chk("t3_fin", 32'(testing_dataset_finished), 32'd1);

    // Last word and am_done in the same cycle
    do_clear(11'd2);
    send_words("t4_q1", 40, 5'd1, 0, 9);
    send_words("t4_q2", 140, 5'd20, 0, 8);
    lif.in_valid = 1'b1; lif.in_data = word_of(140, 9); lif.in_label = 5'd20;
    am_done = 1'b1;
    #0;
    chk("t4_ready_sim", 32'(lif.in_ready), 32'd1);
    tick();
    am_done = 1'b0; lif.in_valid = 1'b0;
    #0;
    chk("t4_done1", 32'(queries_done), 32'd1);
    chk("t4_fin0", 32'(testing_dataset_finished), 32'd0);
    chk("t4_start_t1", 32'(start_querying), 32'd0);
    chk("t4_ready_full", 32'(lif.in_ready), 32'd0);
    tick();
    chk("t4_start_t2", 32'(start_querying), 32'd1);
    chk("t4_cls", 32'(correct_class), 32'd20);
    chk_hv("t4_hv", query_hv, exp_hv(140));
    tick();
    pulse_done();
    chk("t4_done2", 32'(queries_done), 32'd2);
    chk("t4_fin", 32'(testing_dataset_finished), 32'd1);

    // Limits: 30 words offered for a 2-query dataset
    do_clear(11'd2);
    a0 = acc_cnt;
    for (int c = 0; c < 30; c++) begin
      lif.in_valid = 1'b1; lif.in_data = word_of(70, c % 10); lif.in_label = 5'(c / 10);
      tick();
    end
    chk("t5_ready0", 32'(lif.in_ready), 32'd0);
    lif.in_valid = 1'b0;
    chk("t5_acc", 32'(acc_cnt - a0), 32'd20);
    pulse_done();
    chk("t5_done1", 32'(queries_done), 32'd1);
    wait_start("t5_wait_q2");
    chk("t5_cls_q2", 32'(correct_class), 32'd1);
    tick();
    pulse_done();
    chk("t5_done2", 32'(queries_done), 32'd2);
    chk("t5_fin", 32'(testing_dataset_finished), 32'd1);
    pulse_done();
    chk("t5_done_sat", 32'(queries_done), 32'd2);
    chk("t5_fin_hold", 32'(testing_dataset_finished), 32'd1);

    // Empty dataset finishes at once
    do_clear(11'd0);
    a0 = acc_cnt;
    lif.in_valid = 1'b1; lif.in_data = word_of(5, 0);
    #0;
    chk("t5_nq0_ready", 32'(lif.in_ready), 32'd0);
    tick();
    lif.in_valid = 1'b0;
    chk("t5_nq0_fin", 32'(testing_dataset_finished), 32'd1);
    chk("t5_nq0_acc", 32'(acc_cnt - a0), 32'd0);

    // Reset in WAIT_DONE, then clear in the middle of a fill
    do_clear(11'd1);
    send_words("t6_q", 0, 5'd7, 0, 9);
    wait_start("t6_wait");
    tick();
    nrst = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
    chk("t6_rst_ready", 32'(lif.in_ready), 32'd0);
    tick();
    nrst = 1'b1;
    a0 = acc_cnt;
    send_words("t6_part", 50, 5'd2, 0, 3);
    lif.in_valid = 1'b1; lif.in_data = word_of(50, 4); clear = 1'b1;
    #0;
    chk("t6_clr_ready", 32'(lif.in_ready), 32'd0);
    tick();
    clear = 1'b0; lif.in_valid = 1'b0;
    chk("t6_clr_acc", 32'(acc_cnt - a0), 32'd4);
    chk_reset_vals("t6_clr");
    send_words("t6_full", 60, 5'd9, 0, 9);
    wait_start("t6_wait2");
    chk_hv("t6_hv", query_hv, exp_hv(60));
    chk("t6_cls", 32'(correct_class), 32'd9);
    tick();
    pulse_done();
    chk("t6_fin", 32'(testing_dataset_finished), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
